sha_core_scheduler: RTL and testbench
=====================================

Name: sha_core_scheduler

Overview:
- Shares one opt_sha256 compression core among NUM_REQ requesters, for example the per-phase sequencers of bitcoin_hash.
- Arbitrates round-robin and latches the winner's 512-bit block and 256-bit chaining input.
- Drives the core's start/done handshake, then returns the 256-bit digest to the winning requester with a one-cycle valid.
- A watchdog aborts a hung core and reports an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, max cycles in WAIT before abort (1..65535).
- IDX_W, $clog2(NUM_REQ), width of grant index.

Ports:
- clk  in  1  system clock (single clock domain).
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_message  in  NUM_REQ*512  per-requester block; word i of requester r at [r*512+i*32 +: 32].
- req_hin  in  NUM_REQ*256  per-requester chaining value, same packing (8 words).
- gnt  out  NUM_REQ  one-hot; one-cycle pulse when the request is accepted.
- rsp_valid  out  NUM_REQ  one-hot; one-cycle pulse when the result is ready.
- rsp_hout  out  256  digest; valid only while rsp_valid is nonzero.
- rsp_error  out  1  qualifies rsp_valid: 1 = timeout abort; rsp_hout is then all-zero.
- busy  out  1  high in any state other than IDLE.
- core_start  out  1  to opt_sha256 start.
- core_message  out  512  to opt_sha256 message.
- core_hin  out  256  to opt_sha256 hin.
- core_hout  in  256  from opt_sha256 hout.
- core_done  in  1  from opt_sha256 done.

Behaviour:
- Reset (reset_n low at a clk edge) forces:
  - state=IDLE; gnt, rsp_valid, rsp_error, busy, core_start = 0.
  - core_message, core_hin, rsp_hout = 0.
  - round-robin pointer = 0; watchdog = 0.
  - Reset mid-transaction drops the transaction silently: no rsp_valid is issued.
- FSM states:
  - IDLE: if req != 0, pick the winner by round-robin. Search starts at index ptr and wraps; lowest index wins ties from ptr. Then:
    - latch the winner's message/hin into core_message/core_hin;
    - pulse gnt[winner] and store the winner index;
    - ptr <= winner+1 mod NUM_REQ;
    - go to LAUNCH.
  - LAUNCH: core_start <= 1; watchdog <= 0; go to WAIT.
  - WAIT: core_start stays 1 (the core expects a level start); watchdog increments.
    - If core_done = 1: rsp_hout <= core_hout; core_start <= 0; go to RESP.
    - Else if watchdog == TIMEOUT_CYCLES-1: rsp_hout <= 0; set the error flag; core_start <= 0; go to RESP.
    - core_done takes priority over timeout in the same cycle.
  - RESP: rsp_valid[winner] = 1 for exactly one cycle, with rsp_error = error flag. Clear the error flag; go to DRAIN.
  - DRAIN: wait until core_done = 0, so a done still held high is not reused. Then go to IDLE.
- Latency: from request accepted (gnt) to rsp_valid = core latency + 3 cycles (LAUNCH, done capture, RESP).
- Back-to-back: at most one transaction in flight; other requests wait and are not queued.
- Requesters hold req and their data until gnt. Data is sampled only in the gnt cycle, so changes afterwards are ignored.
- A requester that keeps req high after rsp_valid is treated as a new request in the next IDLE arbitration.
- A req dropped before gnt is simply not served.
- Round-robin fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0,...

Decomposition:
- Package sha_sched_pkg:
  - state enum {IDLE, LAUNCH, WAIT, RESP, DRAIN};
  - SHA256_IV constant array (8 words, 6a09e667 ... 5be0cd19);
  - BLOCK_W=512, DIGEST_W=256 localparams.
- Sub-module rr_arbiter:
  - parameter NUM_REQ; inputs req and ptr; outputs one-hot grant, grant index and any_req;
  - purely combinational;
  - tested standalone.

Test Plan:
- Single request: req=0001, req_hin=SHA256_IV, message = padded "abc" block → gnt[0] one pulse; core_start held until done; rsp_valid=0001, rsp_error=0, rsp_hout=ba7816bf...f20015ad.
- Contention: req=1111 held for 4 transactions with a stub core (done after 10 cycles, hout = hin XOR message[255:0]) → gnt order 0,1,2,3; each rsp_valid matches its own requester's data.
- Pointer wrap: after serving requester 3, req=1001 → requester 0 is served next, then 3.
- Timeout: TIMEOUT_CYCLES=20, stub core never asserts done → rsp_valid at LAUNCH+21 with rsp_error=1, rsp_hout=0; busy=0 after DRAIN.
- Sticky done: stub holds core_done high 5 cycles after the first result → FSM stays in DRAIN; the second transaction gets its own fresh result.
- Reset mid-WAIT: reset_n low 1 cycle → all outputs 0, no rsp_valid; the next req=0100 is granted (ptr reset to 0).

Source files
------------

// File: rtl/sha_core_scheduler_pkg.sv
// Shared types and constants for the SHA-256 core scheduler.
package sha_sched_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Word i sits at bits [i*32 +: 32], matching the requester hin packing.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

endpackage

// File: rtl/sha_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps,
// the first asserted request found wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [IDX_W-1:0] cand;

  always_comb begin
    cand      = '0;
    grant_idx = '0;
    any_req   = |req;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        grant_idx = cand;
      end
    end
    grant = any_req ? (ONE << grant_idx) : '0;
  end

endmodule

// File: rtl/sha_core_scheduler.sv
// Shares one SHA-256 compression core among NUM_REQ requesters with
// round-robin arbitration, a start/done handshake and a hang watchdog.
module sha_core_scheduler
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*BLOCK_W-1:0]  req_message,
  input  logic [NUM_REQ*DIGEST_W-1:0] req_hin,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DIGEST_W-1:0]         rsp_hout,
  output logic                        rsp_error,
  output logic                        busy,
  output logic                        core_start,
  output logic [BLOCK_W-1:0]          core_message,
  output logic [DIGEST_W-1:0]         core_hin,
  input  logic [DIGEST_W-1:0]         core_hout,
  input  logic                        core_done,
  output state_t                      fsm_state
);

  // Handshakes: gnt and rsp_valid are single-cycle one-hot pulses; a requester
  // holds req and data until gnt, and data is captured at the end of that cycle.
  localparam logic [15:0]        WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][BLOCK_W-1:0]  msg_arr;
  logic [NUM_REQ-1:0][DIGEST_W-1:0] hin_arr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx, ptr, winner, ptr_nxt;
  logic               arb_any;
  logic [15:0]        watchdog;
  logic               err_flag;

  assign msg_arr = req_message;
  assign hin_arr = req_hin;
  assign ptr_nxt = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_any) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (core_done || (watchdog == WD_LAST)) state_nxt = RESP;
      RESP:    state_nxt = DRAIN;
      DRAIN:   if (!core_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulses are gated by reset_n so a reset cycle never shows a grant or response.
  assign gnt       = (state == IDLE && reset_n) ? arb_grant : '0;
  assign rsp_valid = (state == RESP && reset_n) ? (ONE << winner) : '0;
  assign rsp_error = (state == RESP) && reset_n && err_flag;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      winner       <= '0;
      watchdog     <= '0;
      err_flag     <= 1'b0;
      core_start   <= 1'b0;
      core_message <= '0;
      core_hin     <= '0;
      rsp_hout     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_any) begin
            core_message <= msg_arr[arb_idx];
            core_hin     <= hin_arr[arb_idx];
            winner       <= arb_idx;
            ptr          <= ptr_nxt;
          end
        end
        LAUNCH: begin
          core_start <= 1'b1;
          watchdog   <= '0;
        end
        WAIT: begin
          watchdog <= watchdog + 16'd1;
          // A done arriving on the timeout cycle still counts as success.
          if (core_done) begin
            rsp_hout   <= core_hout;
            core_start <= 1'b0;
          end else if (watchdog == WD_LAST) begin
            rsp_hout   <= '0;
            err_flag   <= 1'b1;
            core_start <= 1'b0;
          end
        end
        RESP:    err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_core_scheduler.sv
// Directed bench for sha_core_scheduler with a behavioural core stub.
module tb_sha_core_scheduler;
  import sha_sched_pkg::*;

  localparam int NR = 4;
  localparam int STUB_LAT = 10;
  localparam logic [511:0] ABC_BLOCK = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [255:0] ABC_DIGEST = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
  };

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req;
  logic [NR*512-1:0] req_message;
  logic [NR*256-1:0] req_hin;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   rsp_valid;
  logic [255:0]    rsp_hout;
  logic            rsp_error;
  logic            busy;
  logic            core_start;
  logic [511:0]    core_message;
  logic [255:0]    core_hin;
  logic [255:0]    core_hout;
  logic            core_done;
  state_t          fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit stub_never;
  int stub_hold;
  bit st_run;
  int st_cnt;
  int st_hold;

  sha_core_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(20)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_message  (req_message),
    .req_hin      (req_hin),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_hout     (rsp_hout),
    .rsp_error    (rsp_error),
    .busy         (busy),
    .core_start   (core_start),
    .core_message (core_message),
    .core_hin     (core_hin),
    .core_hout    (core_hout),
    .core_done    (core_done),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  // ---------------- core stub ----------------
  function automatic logic [255:0] stub_result(input logic [511:0] m, input logic [255:0] h);
    if (m == ABC_BLOCK && h == 256'(SHA256_IV)) return ABC_DIGEST;
    return h ^ m[255:0];
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      st_run    <= 1'b0;
      st_cnt    <= 0;
      st_hold   <= 0;
      core_done <= 1'b0;
      core_hout <= '0;
    end else if (core_done) begin
      if (st_hold > 0) st_hold <= st_hold - 1;
      else core_done <= 1'b0;
    end else if (st_run) begin
      if (!core_start) begin
        st_run <= 1'b0;
      end else if (!stub_never && st_cnt == STUB_LAT) begin
        core_done <= 1'b1;
        core_hout <= stub_result(core_message, core_hin);
        st_run    <= 1'b0;
        st_hold   <= stub_hold;
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end else if (core_start) begin
      st_run <= 1'b1;
      st_cnt <= 1;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [511:0] mk_msg(input int r);
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[i*32 +: 32] = 32'ha0000000 + 32'(r << 8) + 32'(i);
    return m;
  endfunction

  function automatic logic [255:0] mk_hin(input int r);
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = 32'h50000000 + 32'(r << 12) + 32'(i * 3);
    return h;
  endfunction

  function automatic logic [255:0] xor_exp(input logic [511:0] m, input logic [255:0] h);
    return h ^ m[255:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input logic [511:0] m, input logic [255:0] h);
    req_message[r*512 +: 512] = m;
    req_hin[r*256 +: 256] = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant (possibly in the current cycle), then for its response.
  task automatic run_txn(input string tag, input int idx, input logic [255:0] exp_h,
                         input logic exp_err, input int exp_lat);
    int n;
    int t0;
    bit start_ok;
    #1;
    n = 0;
    while (gnt == '0 && n < 60) begin
      step();
      n++;
    end
    check({tag, " gnt_seen"}, 256'(gnt != '0), 256'(1));
    check({tag, " gnt"}, 256'(gnt), 256'(4'b0001 << idx));
    t0 = cyc;
    step();
    check({tag, " gnt_pulse"}, 256'(gnt), 256'(0));
    n = 0;
    start_ok = 1'b1;
    while (rsp_valid == '0 && n < 100) begin
      if (fsm_state == WAIT && !core_start) start_ok = 1'b0;
      step();
      n++;
    end
    check({tag, " rsp_seen"}, 256'(rsp_valid != '0), 256'(1));
    check({tag, " rsp_valid"}, 256'(rsp_valid), 256'(4'b0001 << idx));
    check({tag, " rsp_error"}, 256'(rsp_error), 256'(exp_err));
    check({tag, " rsp_hout"}, rsp_hout, exp_h);
    check({tag, " latency"}, 256'(cyc - t0), 256'(exp_lat));
    check({tag, " start_level"}, 256'(start_ok), 256'(1));
    step();
    check({tag, " rsp_pulse"}, 256'(rsp_valid), 256'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int rsp_cnt;
    logic [511:0] m2;
    logic [255:0] h2;

    reset_n = 1'b0;
    req = '0;
    req_message = '0;
    req_hin = '0;
    stub_never = 1'b0;
    stub_hold = 0;
    repeat (3) step();
    check("rst gnt", 256'(gnt), 256'(0));
    check("rst rsp_valid", 256'(rsp_valid), 256'(0));
    check("rst rsp_error", 256'(rsp_error), 256'(0));
    check("rst busy", 256'(busy), 256'(0));
    check("rst core_start", 256'(core_start), 256'(0));
    check("rst core_message", core_message[255:0] | core_message[511:256], 256'(0));
    check("rst core_hin", core_hin, 256'(0));
    check("rst rsp_hout", rsp_hout, 256'(0));
    check("rst state", 256'(fsm_state), 256'(IDLE));
    reset_n = 1'b1;
    step();

    // Contention: all four requesters, grants must rotate 0,1,2,3.
    for (int r = 0; r < NR; r++) load(r, mk_msg(r), mk_hin(r));
    req = 4'b1111;
    for (int r = 0; r < NR; r++) run_txn($sformatf("cont%0d", r), r, xor_exp(mk_msg(r), mk_hin(r)), 1'b0, 14);
    req = '0;
    step();

    // Pointer wrap: after requester 3, 1001 serves 0 then 3.
    req = 4'b1001;
    run_txn("wrap0", 0, xor_exp(mk_msg(0), mk_hin(0)), 1'b0, 14);
    run_txn("wrap3", 3, xor_exp(mk_msg(3), mk_hin(3)), 1'b0, 14);
    req = '0;
    step();

    // Single "abc" block from the standard IV.
    load(0, ABC_BLOCK, 256'(SHA256_IV));
    req = 4'b0001;
    run_txn("abc", 0, ABC_DIGEST, 1'b0, 14);
    req = '0;
    step();
    check("abc idle_busy", 256'(busy), 256'(0));

    // Sticky done: FSM must sit in DRAIN until the core releases done.
    stub_hold = 5;
    req = 4'b0010;
    run_txn("sticky1", 1, xor_exp(mk_msg(1), mk_hin(1)), 1'b0, 14);
    req = '0;
    repeat (2) step();
    check("sticky drain", 256'(fsm_state), 256'(DRAIN));
    check("sticky busy", 256'(busy), 256'(1));
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check("sticky released", 256'(busy), 256'(0));
    stub_hold = 0;
    m2 = mk_msg(5);
    h2 = mk_hin(6);
    load(1, m2, h2);
    req = 4'b0010;
    run_txn("sticky2", 1, xor_exp(m2, h2), 1'b0, 14);
    req = '0;
    step();

    // Timeout: the core never answers.
    stub_never = 1'b1;
    req = 4'b0100;
    run_txn("tmo", 2, 256'(0), 1'b1, 22);
    req = '0;
    step();
    check("tmo busy", 256'(busy), 256'(0));
    stub_never = 1'b0;
    step();

    // Reset mid-WAIT: silent drop, pointer back to 0.
    req = 4'b0010;
    #1;
    n = 0;
    while (gnt == '0 && n < 60) begin
      step();
      n++;
    end
    check("rstw gnt", 256'(gnt), 256'(4'b0010));
    step();
    req = '0;
    repeat (4) step();
    check("rstw in_wait", 256'(fsm_state), 256'(WAIT));
    reset_n = 1'b0;
    step();
    check("rstw gnt0", 256'(gnt), 256'(0));
    check("rstw rsp0", 256'(rsp_valid), 256'(0));
    check("rstw err0", 256'(rsp_error), 256'(0));
    check("rstw busy0", 256'(busy), 256'(0));
    check("rstw start0", 256'(core_start), 256'(0));
    check("rstw msg0", core_message[255:0] | core_message[511:256], 256'(0));
    check("rstw hin0", core_hin, 256'(0));
    check("rstw hout0", rsp_hout, 256'(0));
    reset_n = 1'b1;
    rsp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid != '0) rsp_cnt++;
    end
    check("rstw no_rsp", 256'(rsp_cnt), 256'(0));
    load(1, mk_msg(1), mk_hin(1));
    load(2, mk_msg(2), mk_hin(2));
    req = 4'b0110;
    run_txn("rstw next", 1, xor_exp(mk_msg(1), mk_hin(1)), 1'b0, 14);
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
